// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU control encodings, operand-B
// select encodings and the ID/EX register record with its cleared (bubble) value.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 5;
  localparam int SHAMT_W    = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD = 5'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB = 5'd1;
  localparam logic [CTRL_W-1:0] ALU_AND = 5'd2;
  localparam logic [CTRL_W-1:0] ALU_OR  = 5'd3;
  localparam logic [CTRL_W-1:0] ALU_XOR = 5'd4;
  localparam logic [CTRL_W-1:0] ALU_NOR = 5'd5;
  localparam logic [CTRL_W-1:0] ALU_SLT = 5'd6;
  localparam logic [CTRL_W-1:0] ALU_SLL = 5'd7;
  localparam logic [CTRL_W-1:0] ALU_SRL = 5'd8;
  localparam logic [CTRL_W-1:0] ALU_SRA = 5'd9;

  typedef enum logic [1:0] {
    SRC_B_RT    = 2'd0,
    SRC_B_IMM   = 2'd1,
    SRC_B_SHAMT = 2'd2,
    SRC_B_RSVD  = 2'd3
  } src_b_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [SHAMT_W-1:0]    shamt;
    logic                  src_a_sel;
    src_b_sel_e            src_b_sel;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_reg_t;

  // A bubble is an all-zero record: not valid, ADD, no writes, operands 0.
  localparam id_ex_reg_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between ID, the forwarding sources and the ID/EX operand stage.
// master = upstream/hazard side, slave = the stage itself.
interface id_ex_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_ADDR_W,
  parameter int CW = CTRL_W
);
  logic          id_valid;
  logic [CW-1:0] id_alu_ctrl;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic          id_src_a_sel;
  logic [1:0]    id_src_b_sel;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          stall;
  logic          flush;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          ex_valid;
  logic [CW-1:0] ctrl;
  logic [DW-1:0] selected_A;
  logic [DW-1:0] selected_B;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [DW-1:0] ex_store_data;
  logic          load_use_stall;

  modport master (
    output id_valid, id_alu_ctrl, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_a_sel, id_src_b_sel, id_reg_write,
           id_mem_read, id_mem_write, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, ctrl, selected_A, selected_B, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_alu_ctrl, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_src_a_sel, id_src_b_sel, id_reg_write,
           id_mem_read, id_mem_write, stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, ctrl, selected_A, selected_B, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats the value read at ID.
// Register 0 is hardwired, so it is never forwarded.
module fwd_mux #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0]     stored,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd
);

  always_comb begin
    // NOTE: assign a default first so every path writes fwd and no latch is inferred.
    fwd = stored;
    if (idx != '0) begin
      if (exmem_reg_write && exmem_rd == idx)
        fwd = exmem_result;
      else if (memwb_reg_write && memwb_rd == idx)
        fwd = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with combinational operand forwarding into the ALU.
// Optional macro LOAD_USE_DETECT_EN: detect load-use hazards here and self-insert bubbles.
module id_ex_operand_stage
  import cpu_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  id_ex_operand_stage_if.slave  bus
);

  id_ex_reg_t        q;
  id_ex_reg_t        d_load;
  logic              load_use;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Side-effecting control bits only survive for a real instruction.
  always_comb begin
    d_load           = BUBBLE;
    d_load.valid     = bus.id_valid;
    d_load.ctrl      = bus.id_alu_ctrl;
    d_load.rd        = bus.id_rd;
    d_load.rs        = bus.id_rs;
    d_load.rt        = bus.id_rt;
    d_load.rs_data   = bus.id_rs_data;
    d_load.rt_data   = bus.id_rt_data;
    d_load.imm       = bus.id_imm;
    d_load.shamt     = bus.id_shamt;
    d_load.src_a_sel = bus.id_src_a_sel;
    d_load.src_b_sel = src_b_sel_e'(bus.id_src_b_sel);
    d_load.reg_write = bus.id_valid & bus.id_reg_write;
    d_load.mem_read  = bus.id_valid & bus.id_mem_read;
    d_load.mem_write = bus.id_valid & bus.id_mem_write;
  end

`ifdef LOAD_USE_DETECT_EN
  // rt only matters when it is actually consumed: as operand B, store data or shifted source.
  assign load_use = bus.id_valid && q.valid && q.mem_read && (q.rd != '0) &&
                    ((q.rd == bus.id_rs) ||
                     ((q.rd == bus.id_rt) &&
                      ((bus.id_src_b_sel == 2'(SRC_B_RT)) || bus.id_mem_write || bus.id_src_a_sel)));
`else
  assign load_use = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: pipeline state uses non-blocking assignments so all registers update together.
    if (rst || bus.flush || load_use)
      q <= BUBBLE;
    else if (!bus.stall)
      q <= d_load;
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .idx(q.rs), .stored(q.rs_data),
    .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
    .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
    .fwd(fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .idx(q.rt), .stored(q.rt_data),
    .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
    .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
    .fwd(fwd_rt)
  );

  always_comb begin
    bus.selected_A = q.src_a_sel ? fwd_rt : fwd_rs;
    bus.selected_B = '0;
    unique case (q.src_b_sel)
      SRC_B_RT:    bus.selected_B = fwd_rt;
      SRC_B_IMM:   bus.selected_B = q.imm;
      SRC_B_SHAMT: bus.selected_B = {{(DATA_W-SHAMT_W){1'b0}}, q.shamt};
      SRC_B_RSVD:  bus.selected_B = '0;
    endcase
  end

  assign bus.ex_valid       = q.valid;
  assign bus.ctrl           = q.ctrl;
  assign bus.ex_rd          = q.rd;
  assign bus.ex_reg_write   = q.reg_write;
  assign bus.ex_mem_read    = q.mem_read;
  assign bus.ex_mem_write   = q.mem_write;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations are hand-computed constants.
// Build with or without LOAD_USE_DETECT_EN; the load-use scenario follows the macro.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] ctrl,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [31:0] imm, input logic [4:0] shamt,
                          input logic a_sel, input logic [1:0] b_sel,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid     = v;     bus.id_alu_ctrl  = ctrl;
    bus.id_rs        = rs;    bus.id_rt        = rt;    bus.id_rd = rd;
    bus.id_rs_data   = rs_d;  bus.id_rt_data   = rt_d;
    bus.id_imm       = imm;   bus.id_shamt     = shamt;
    bus.id_src_a_sel = a_sel; bus.id_src_b_sel = b_sel;
    bus.id_reg_write = rw;    bus.id_mem_read  = mr;    bus.id_mem_write = mw;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    clear_fwd();
    drive_id(1, ALU_SUB, 1, 2, 3, 32'h11, 32'h22, 0, 0, 0, 0, 1, 1, 1);
    step(); step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.ctrl !== 5'd0) $display("FAIL reset_ctrl: got %0h expected 0", bus.ctrl); else n_pass++;
    n_total++; if (bus.ex_reg_write !== 1'b0) $display("FAIL reset_reg_write: got %0h expected 0", bus.ex_reg_write); else n_pass++;
    n_total++; if (bus.selected_A !== 32'h0) $display("FAIL reset_selA: got %0h expected 0", bus.selected_A); else n_pass++;
    n_total++; if (bus.selected_B !== 32'h0) $display("FAIL reset_selB: got %0h expected 0", bus.selected_B); else n_pass++;
    rst = 1'b0;
    drive_id(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL idle_valid: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.selected_A !== 32'h0) $display("FAIL idle_selA: got %0h expected 0", bus.selected_A); else n_pass++;
    n_total++; if (bus.load_use_stall !== 1'b0) $display("FAIL idle_lus: got %0h expected 0", bus.load_use_stall); else n_pass++;
  endtask

  task automatic test_load();
    drive_id(1, ALU_ADD, 1, 2, 3, 32'd5, 32'd7, 32'h1234, 5'd4, 0, SRC_B_RT, 1, 0, 0);
    step();
    n_total++; if (bus.ex_valid !== 1'b1) $display("FAIL add_valid: got %0h expected 1", bus.ex_valid); else n_pass++;
    n_total++; if (bus.ctrl !== ALU_ADD) $display("FAIL add_ctrl: got %0h expected 0", bus.ctrl); else n_pass++;
    n_total++; if (bus.selected_A !== 32'd5) $display("FAIL add_selA: got %0h expected 5", bus.selected_A); else n_pass++;
    n_total++; if (bus.selected_B !== 32'd7) $display("FAIL add_selB: got %0h expected 7", bus.selected_B); else n_pass++;
    n_total++; if (bus.ex_rd !== 5'd3) $display("FAIL add_rd: got %0h expected 3", bus.ex_rd); else n_pass++;
    n_total++; if (bus.ex_reg_write !== 1'b1) $display("FAIL add_rw: got %0h expected 1", bus.ex_reg_write); else n_pass++;
    n_total++; if (bus.ex_store_data !== 32'd7) $display("FAIL add_store: got %0h expected 7", bus.ex_store_data); else n_pass++;
    // sll: A from rt, B = zero-extended shamt
    drive_id(1, ALU_SLL, 0, 2, 4, 32'd0, 32'd7, 32'h1234, 5'd4, 1, SRC_B_SHAMT, 1, 0, 0);
    step();
    n_total++; if (bus.ctrl !== ALU_SLL) $display("FAIL sll_ctrl: got %0h expected 7", bus.ctrl); else n_pass++;
    n_total++; if (bus.selected_A !== 32'd7) $display("FAIL sll_selA: got %0h expected 7", bus.selected_A); else n_pass++;
    n_total++; if (bus.selected_B !== 32'd4) $display("FAIL sll_selB: got %0h expected 4", bus.selected_B); else n_pass++;
    // immediate is never forwarded, even with a matching rt
    drive_id(1, ALU_OR, 1, 2, 5, 32'd5, 32'd7, 32'h1234, 5'd0, 0, SRC_B_IMM, 1, 0, 0);
    step();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd2; bus.exmem_result = 32'hABC;
    #1;
    n_total++; if (bus.selected_B !== 32'h1234) $display("FAIL imm_selB: got %0h expected 1234", bus.selected_B); else n_pass++;
    n_total++; if (bus.ex_store_data !== 32'hABC) $display("FAIL imm_store_fwd: got %0h expected abc", bus.ex_store_data); else n_pass++;
    clear_fwd();
    drive_id(1, ALU_OR, 1, 2, 5, 32'd5, 32'd7, 32'h1234, 5'd9, 0, SRC_B_RSVD, 1, 0, 0);
    step();
    n_total++; if (bus.selected_B !== 32'h0) $display("FAIL rsvd_selB: got %0h expected 0", bus.selected_B); else n_pass++;
    // invalid instruction: control bits gated off
    drive_id(0, ALU_ADD, 1, 2, 6, 32'd5, 32'd7, 0, 0, 0, SRC_B_RT, 1, 1, 1);
    step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL gate_valid: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 3'b000)
      $display("FAIL gate_ctrl_bits: got %0b expected 000", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}); else n_pass++;
  endtask

  task automatic test_forwarding();
    drive_id(1, ALU_ADD, 1, 2, 3, 32'd5, 32'd7, 0, 0, 0, SRC_B_RT, 1, 0, 0);
    step();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_result = 32'h100;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd1; bus.memwb_result = 32'h200;
    #1;
    n_total++; if (bus.selected_A !== 32'h100) $display("FAIL fwd_exmem_wins: got %0h expected 100", bus.selected_A); else n_pass++;
    n_total++; if (bus.selected_B !== 32'd7) $display("FAIL fwd_B_untouched: got %0h expected 7", bus.selected_B); else n_pass++;
    bus.exmem_reg_write = 1'b0;
    #1;
    n_total++; if (bus.selected_A !== 32'h200) $display("FAIL fwd_memwb: got %0h expected 200", bus.selected_A); else n_pass++;
    bus.memwb_rd = 5'd2; bus.memwb_result = 32'h300;
    #1;
    n_total++; if (bus.selected_A !== 32'd5) $display("FAIL fwd_A_stored: got %0h expected 5", bus.selected_A); else n_pass++;
    n_total++; if (bus.selected_B !== 32'h300) $display("FAIL fwd_memwb_B: got %0h expected 300", bus.selected_B); else n_pass++;
    n_total++; if (bus.ex_store_data !== 32'h300) $display("FAIL fwd_store: got %0h expected 300", bus.ex_store_data); else n_pass++;
    clear_fwd();
  endtask

  task automatic test_zero_reg();
    drive_id(1, ALU_ADD, 0, 2, 3, 32'd5, 32'd7, 0, 0, 0, SRC_B_RT, 1, 0, 0);
    step();
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hDEAD;
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hBEEF;
    #1;
    n_total++; if (bus.selected_A !== 32'd5) $display("FAIL zero_reg_no_fwd: got %0h expected 5", bus.selected_A); else n_pass++;
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    drive_id(1, ALU_SUB, 4, 5, 6, 32'h44, 32'h55, 0, 0, 0, SRC_B_RT, 1, 0, 0);
    step();
    bus.stall = 1'b1;
    drive_id(1, ALU_XOR, 7, 8, 9, 32'h77, 32'h88, 0, 0, 0, SRC_B_RT, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (bus.ctrl !== ALU_SUB) $display("FAIL stall_ctrl[%0d]: got %0h expected 1", i, bus.ctrl); else n_pass++;
      n_total++; if (bus.selected_A !== 32'h44) $display("FAIL stall_selA[%0d]: got %0h expected 44", i, bus.selected_A); else n_pass++;
      n_total++; if (bus.ex_rd !== 5'd6) $display("FAIL stall_rd[%0d]: got %0h expected 6", i, bus.ex_rd); else n_pass++;
      n_total++; if (bus.ex_mem_read !== 1'b0) $display("FAIL stall_mr[%0d]: got %0h expected 0", i, bus.ex_mem_read); else n_pass++;
    end
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_result = 32'h999;
    #1;
    n_total++; if (bus.selected_A !== 32'h999) $display("FAIL stall_fwd_tracks: got %0h expected 999", bus.selected_A); else n_pass++;
    clear_fwd();
    bus.flush = 1'b1;
    step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL flush_over_stall_valid: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.ctrl !== 5'd0) $display("FAIL flush_ctrl: got %0h expected 0", bus.ctrl); else n_pass++;
    n_total++; if (bus.ex_reg_write !== 1'b0) $display("FAIL flush_rw: got %0h expected 0", bus.ex_reg_write); else n_pass++;
    bus.flush = 1'b0; bus.stall = 1'b0;
    drive_id(1, ALU_AND, 4, 5, 6, 32'h44, 32'h55, 0, 0, 0, SRC_B_RT, 1, 0, 0);
    step();
    n_total++; if (bus.ctrl !== ALU_AND) $display("FAIL reload_ctrl: got %0h expected 2", bus.ctrl); else n_pass++;
    bus.stall = 1'b1; rst = 1'b1;
    step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_mid_stall_valid: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.ex_rd !== 5'd0) $display("FAIL rst_mid_stall_rd: got %0h expected 0", bus.ex_rd); else n_pass++;
    rst = 1'b0; bus.stall = 1'b0;
  endtask

  task automatic test_load_use();
    // lw $3
    drive_id(1, ALU_ADD, 1, 0, 3, 32'd5, 32'd0, 32'd8, 0, 0, SRC_B_IMM, 1, 1, 0);
    step();
    n_total++; if (bus.ex_mem_read !== 1'b1) $display("FAIL lw_mem_read: got %0h expected 1", bus.ex_mem_read); else n_pass++;
    // add $8 = $3 + $2
    drive_id(1, ALU_ADD, 3, 2, 8, 32'd0, 32'd7, 0, 0, 0, SRC_B_RT, 1, 0, 0);
    #1;
`ifdef LOAD_USE_DETECT_EN
    n_total++; if (bus.load_use_stall !== 1'b1) $display("FAIL lu_asserted: got %0h expected 1", bus.load_use_stall); else n_pass++;
    step();
    n_total++; if (bus.ex_valid !== 1'b0) $display("FAIL lu_bubble: got %0h expected 0", bus.ex_valid); else n_pass++;
    n_total++; if (bus.load_use_stall !== 1'b0) $display("FAIL lu_released: got %0h expected 0", bus.load_use_stall); else n_pass++;
    step();
    n_total++; if ({bus.ex_valid, bus.ex_rd} !== {1'b1, 5'd8}) $display("FAIL lu_add_loaded: got %0h expected 28", {bus.ex_valid, bus.ex_rd}); else n_pass++;
    // lw $3 then addi rt=$3 as destination-only: no hazard
    drive_id(1, ALU_ADD, 1, 0, 3, 32'd5, 32'd0, 32'd8, 0, 0, SRC_B_IMM, 1, 1, 0);
    step();
    drive_id(1, ALU_ADD, 1, 3, 3, 32'd5, 32'd0, 32'd4, 0, 0, SRC_B_IMM, 1, 0, 0);
    #1;
    n_total++; if (bus.load_use_stall !== 1'b0) $display("FAIL lu_rt_unused: got %0h expected 0", bus.load_use_stall); else n_pass++;
`else
    n_total++; if (bus.load_use_stall !== 1'b0) $display("FAIL lu_tied_low: got %0h expected 0", bus.load_use_stall); else n_pass++;
    step();
    n_total++; if ({bus.ex_valid, bus.ex_rd} !== {1'b1, 5'd8}) $display("FAIL lu_add_loaded: got %0h expected 28", {bus.ex_valid, bus.ex_rd}); else n_pass++;
    n_total++; if (bus.ex_mem_read !== 1'b0) $display("FAIL lu_add_mr: got %0h expected 0", bus.ex_mem_read); else n_pass++;
`endif
    drive_id(0, ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_forwarding();
    test_zero_reg();
    test_stall_flush();
    test_load_use();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
